// File: rtl/core_pkg.sv
// Shared widths, constants and state encoding for the fetch slice.
package core_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StTrap
  } fetch_state_e;

  // Sequential word address; wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bundle: imem request/response, decode handoff and redirect from execute.
interface fetch_if;
  import core_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              fetch_trap;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_trap,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_trap,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry response buffer with same-cycle push/pop and a synchronous flush.
module fetch_fifo #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & (count_q != 2'd0);
    // When full, the slot freed by the pop is the one the push lands in.
    do_push  = push_i & ((count_q != 2'd2) | do_pop);
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: in-order imem requests, response buffering, redirect with stale drop.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of masking them.
module fetch
  import core_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned       MAX_OUTSTANDING = 2
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [1:0]        outstanding_q, outstanding_d;
  logic [1:0]        drop_cnt_q, drop_cnt_d;

  logic                     grant, push, pop, flush, misaligned, fifo_empty;
  logic [ADDR_W-1:0]        target_pc;
  logic [1:0]               fifo_count;
  logic [ADDR_W+INST_W-1:0] fifo_rdata;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc  = bus.redirect_pc;
  assign misaligned = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
`else
  assign target_pc  = bus.redirect_pc & ~32'h3;
  assign misaligned = 1'b0;
`endif

  // Requests only when every in-flight response is sure of a buffer slot.
  assign bus.imem_req  = (state_q == StRun) && (outstanding_q < MaxOut) &&
                         (({1'b0, outstanding_q} + {1'b0, fifo_count}) < 3'd2);
  assign bus.imem_addr = fetch_pc_q;

  assign flush = bus.redirect;
  assign grant = bus.imem_req & bus.imem_gnt;
  assign pop   = bus.inst_valid & bus.inst_ready & ~flush;
  assign push  = bus.imem_rvalid & (drop_cnt_q == 2'd0) & ~flush;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, bus.imem_rvalid};
    drop_cnt_d    = drop_cnt_q;

    if (grant) fetch_pc_d = pc_inc(fetch_pc_q);
    if (push)  resp_pc_d  = pc_inc(resp_pc_q);

    if (bus.redirect) begin
      // Everything still in flight after this edge, including this cycle's grant, is stale.
      drop_cnt_d = outstanding_d;
      if (!misaligned) begin
        fetch_pc_d = target_pc;
        resp_pc_d  = target_pc;
      end
    end else if (bus.imem_rvalid && (drop_cnt_q != 2'd0)) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end

    case (state_q)
      StBoot:  state_d = misaligned ? StTrap : StRun;
      StRun:   if (misaligned) state_d = StTrap;
      StTrap:  if (bus.redirect && !misaligned) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .Width(ADDR_W + INST_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({resp_pc_q, bus.imem_rdata}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst       = fifo_rdata[INST_W-1:0];
  assign bus.inst_pc    = fifo_rdata[ADDR_W+INST_W-1:INST_W];
  assign bus.fetch_trap = (state_q == StTrap);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: an in-order imem model answers grants one cycle later unless held.
module tb_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rsp_hold = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] pend[$];

  fetch_if bus ();

  fetch #(
    .RESET_PC        (32'h0000_0000),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h002081b3 : (32'hA000_0000 | a);
  endfunction

  // Advance one cycle and play the imem model; leaves time 1 unit after the rising edge.
  task automatic step();
    logic g, r;
    logic [31:0] a;
    g = bus.imem_req & bus.imem_gnt;
    a = bus.imem_addr;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end else begin
      if (g) pend.push_back(a);
      if (!rsp_hold && pend.size() != 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word(pend.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_gnt = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    rsp_hold = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req got %h want 0", bus.imem_req);
    else n_pass++;
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rst_valid got %h want 0", bus.inst_valid);
    else n_pass++;
    n_chk++; if (bus.inst !== 32'h0) $display("FAIL rst_inst got %h want 0", bus.inst);
    else n_pass++;
    n_chk++; if (bus.inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h want 0", bus.inst_pc);
    else n_pass++;
    n_chk++; if (bus.fetch_trap !== 1'b0) $display("FAIL rst_trap got %h want 0", bus.fetch_trap);
    else n_pass++;
    rst = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL boot_req got %h want 0", bus.imem_req);
    else n_pass++;
  endtask

  task automatic test_fetch();
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
      $display("FAIL fetch_c1 got req=%h addr=%h want 1/0", bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4)
      $display("FAIL fetch_c2 got req=%h addr=%h want 1/4", bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h002081b3 || bus.inst_pc !== 32'h0)
      $display("FAIL fetch_first got v=%h inst=%h pc=%h want 1/002081b3/0",
               bus.inst_valid, bus.inst, bus.inst_pc);
    else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL fetch_c3_req got %h want 0", bus.imem_req);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_pc !== 32'h4 || bus.inst !== 32'hA000_0004)
      $display("FAIL fetch_second got pc=%h inst=%h want 4/a0000004", bus.inst_pc, bus.inst);
    else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
      $display("FAIL fetch_c4 got req=%h addr=%h want 1/8", bus.imem_req, bus.imem_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.imem_gnt = 1'b1;
    step();
    step();
    for (int c = 3; c <= 5; c++) begin
      step();
      n_chk++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0)
        $display("FAIL bp_hold_c%0d got req=%h v=%h pc=%h want 0/1/0",
                 c, bus.imem_req, bus.inst_valid, bus.inst_pc);
      else n_pass++;
    end
    step();
    bus.inst_ready = 1'b1;
    n_chk++; if (bus.inst_pc !== 32'h0 || bus.inst !== 32'h002081b3)
      $display("FAIL bp_rel0 got pc=%h inst=%h want 0/002081b3", bus.inst_pc, bus.inst);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4)
      $display("FAIL bp_rel1 got v=%h pc=%h want 1/4", bus.inst_valid, bus.inst_pc);
    else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8)
      $display("FAIL bp_req_resume got req=%h addr=%h want 1/8", bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL bp_nodup got %h want 0", bus.inst_valid);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8)
      $display("FAIL bp_next got v=%h pc=%h want 1/8", bus.inst_valid, bus.inst_pc);
    else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.inst_ready = 1'b1;
    rsp_hold = 1'b1;
    step();
    step();
    step();
    n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rd_maxout got %h want 0", bus.imem_req);
    else n_pass++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    rsp_hold = 1'b0;
    n_chk++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0)
      $display("FAIL rd_c4 got v=%h req=%h want 0/0", bus.inst_valid, bus.imem_req);
    else n_pass++;
    step();
    step();
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rd_drop0 got %h want 0", bus.inst_valid);
    else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
      $display("FAIL rd_newreq got req=%h addr=%h want 1/100", bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rd_drop1 got %h want 0", bus.inst_valid);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== 32'hA000_0100)
      $display("FAIL rd_target got v=%h pc=%h inst=%h want 1/100/a0000100",
               bus.inst_valid, bus.inst_pc, bus.inst);
    else n_pass++;
  endtask

  task automatic test_redirect_push_pop();
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    step();
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.imem_rvalid !== 1'b1)
      $display("FAIL rpp_pre got v=%h rvalid=%h want 1/1", bus.inst_valid, bus.imem_rvalid);
    else n_pass++;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rpp_empty got %h want 0", bus.inst_valid);
    else n_pass++;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
      $display("FAIL rpp_req got req=%h addr=%h want 1/100", bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL rpp_nopush got %h want 0", bus.inst_valid);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100)
      $display("FAIL rpp_target got v=%h pc=%h want 1/100", bus.inst_valid, bus.inst_pc);
    else n_pass++;
  endtask

  task automatic test_misalign();
    do_reset();
    bus.imem_gnt = 1'b1;
    bus.inst_ready = 1'b1;
    step();
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 3; c <= 4; c++) begin
      n_chk++; if (bus.fetch_trap !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0)
        $display("FAIL trap_c%0d got trap=%h req=%h v=%h want 1/0/0",
                 c, bus.fetch_trap, bus.imem_req, bus.inst_valid);
      else n_pass++;
      if (c == 3) step();
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect = 1'b0;
    n_chk++; if (bus.fetch_trap !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200)
      $display("FAIL trap_exit got trap=%h req=%h addr=%h want 0/1/200",
               bus.fetch_trap, bus.imem_req, bus.imem_addr);
    else n_pass++;
`else
    n_chk++; if (bus.fetch_trap !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
      $display("FAIL mask_req got trap=%h req=%h addr=%h want 0/1/100",
               bus.fetch_trap, bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b0) $display("FAIL mask_drop got %h want 0", bus.inst_valid);
    else n_pass++;
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst !== 32'hA000_0100)
      $display("FAIL mask_target got v=%h pc=%h inst=%h want 1/100/a0000100",
               bus.inst_valid, bus.inst_pc, bus.inst);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.imem_gnt = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    step();
    rst = 1'b0;
    bus.redirect = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.fetch_trap !== 1'b0)
      $display("FAIL mid_ctrl got req=%h v=%h trap=%h want 0/0/0",
               bus.imem_req, bus.inst_valid, bus.fetch_trap);
    else n_pass++;
    n_chk++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0)
      $display("FAIL mid_data got inst=%h pc=%h want 0/0", bus.inst, bus.inst_pc);
    else n_pass++;
    step();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
      $display("FAIL mid_restart got req=%h addr=%h want 1/0", bus.imem_req, bus.imem_addr);
    else n_pass++;
    step();
    step();
    n_chk++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== 32'h002081b3)
      $display("FAIL mid_first got v=%h pc=%h inst=%h want 1/0/002081b3",
               bus.inst_valid, bus.inst_pc, bus.inst);
    else n_pass++;
  endtask

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect();
    test_redirect_push_pop();
    test_misalign();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted but unreturned imem requests (range 1..2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_req, output, 1, fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32, fetch byte address, word aligned.
REQ-007 SHALL have port imem_gnt, input, 1, request accepted when imem_req && imem_gnt.
REQ-008 SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 32), carrying the in-order response no earlier than the cycle after grant.
REQ-009 SHALL have ports inst (output, 32), inst_pc (output, 32) and inst_valid (output, 1), forming the instruction word to decode.
REQ-010 SHALL have port inst_ready, input, 1; decode consumes on inst_valid && inst_ready.
REQ-011 SHALL have ports redirect (input, 1) and redirect_pc (input, 32), for a branch/jump target from execute.
REQ-012 SHALL have port fetch_trap, output, 1, raised for a misaligned redirect target (macro-dependent).

Function
REQ-013 SHALL keep fetch_pc, the next request address, and advance it by 4 on each grant.
REQ-014 SHALL buffer responses in a 2-entry FIFO with entries {pc, inst}; the head drives inst/inst_pc, and inst_valid = !empty.
REQ-015 SHALL assert imem_req only when outstanding < MAX_OUTSTANDING and outstanding + FIFO occupancy < 2, so every response is guaranteed a slot.
REQ-016 SHALL support push and pop in the same cycle; when the FIFO is full, the pop frees the slot used by the push.
REQ-017 SHALL make imem_addr and imem_req stable while imem_req && !imem_gnt.
REQ-018 SHALL, on redirect, flush the FIFO and drop inst_valid next cycle, load fetch_pc <= redirect_pc, and set drop_cnt <= outstanding, counting a response that arrives in the same cycle.
REQ-019 SHALL discard responses while drop_cnt > 0 and decrement drop_cnt on each one; new-target responses are accepted only after drop_cnt reaches 0.
REQ-020 SHALL give redirect priority over a simultaneous grant, push and pop; a grant in the redirect cycle still counts as outstanding and is dropped.
REQ-021 SHALL implement a state machine with states BOOT, RUN and TRAP: BOOT lasts 1 cycle after reset, then RUN; RUN goes to TRAP per REQ-028; TRAP goes to RUN on an aligned redirect.
REQ-022 SHALL have a best-case latency of 2 cycles from grant to inst_valid when imem returns the cycle after grant.
REQ-023 SHALL let fetch_pc wrap 32'hFFFF_FFFC to 32'h0000_0000 silently.

Reset
REQ-024 SHALL, on rst, set state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0 and fetch_trap=0.
REQ-025 SHALL give rst precedence over redirect and all handshakes, including mid-transaction; responses to pre-reset grants SHALL be ignored for 2 cycles after reset deassertion by a bench contract (imem is reset too).

Configuration
REQ-026 SHALL support macro FETCH_MISALIGN_TRAP_EN.
REQ-027 SHALL, without the macro, force redirect_pc[1:0] to 0, hold fetch_trap at 0 and never enter the TRAP state.
REQ-028 SHALL, with the macro, enter TRAP on a redirect with redirect_pc[1:0] != 0: fetch_trap=1, imem_req=0, FIFO flushed and the remaining outstanding responses dropped.

Structure
REQ-029 SHALL place the state enum, INST_W=32, ADDR_W=32 and the NOP value 32'h0000_0013 in a shared package, core_pkg.
REQ-030 SHALL implement the FIFO as sub-module fetch_fifo (2 entries, width 64, flush input); the counters and FSM stay in fetch.

Verification
REQ-031 SHALL check reset release with gnt=1 and 1-cycle rvalid: imem_addr 0x0, 0x4, 0x8; rdata 0x002081b3 at 0x0 gives inst=0x002081b3, inst_pc=0x0, 2 cycles after grant.
REQ-032 SHALL check backpressure inst_ready=0 for 5 cycles: at most 2 words buffered, imem_req=0 once full, no loss and no duplication on release.
REQ-033 SHALL check redirect to 0x100 with 2 outstanding: both stale responses are dropped and the next inst_pc=0x100.
REQ-034 SHALL check redirect in the same cycle as a push and a pop: the FIFO is empty next cycle and the pushed word is not presented.
REQ-035 SHALL check the macro: with it defined, redirect_pc=0x102 gives fetch_trap=1 and imem_req=0 until a redirect to 0x200; without it, the fetch goes to 0x100.
REQ-036 SHALL check rst asserted mid-burst: all outputs equal REQ-024 values next cycle and the first request goes to RESET_PC.
